// File: rtl/gpu_net_tx_arbiter_if.sv
// rtl/gpu_net_tx_arbiter_if.sv - requester and NI handshake bundle for gpu_net_tx_arbiter
//
// Purpose: groups the per-requester flit handshake and the NI TX handshake
// into one bundle so the arbiter and its surroundings connect through a
// single port.
//
// Signals:
//   req_valid     [NUM_REQ]         per-requester flit valid
//   req_data      [NUM_REQ*FLIT_W]  requester k flit at [k*FLIT_W +: FLIT_W]
//   req_last      [NUM_REQ]         flit closes its packet
//   req_ready     [NUM_REQ]         flit accepted this cycle (one-hot or zero)
//   net_data_out  [FLIT_W]          registered flit to NI
//   net_valid_out                   registered flit valid to NI
//   net_ready_in                    NI accepts flit
//
// Modports:
//   master - requester/NI side (drives requests and NI ready)
//   slave  - arbiter side
interface gpu_net_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 16
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FLIT_W-1:0]         net_data_out;
  logic                      net_valid_out;
  logic                      net_ready_in;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output net_ready_in,
    input  req_ready,
    input  net_data_out,
    input  net_valid_out
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  net_ready_in,
    output req_ready,
    output net_data_out,
    output net_valid_out
  );

endinterface

// File: rtl/gpu_net_tx_arbiter.sv
// rtl/gpu_net_tx_arbiter.sv - round-robin arbiter sharing one NI TX port between requesters
//
// Purpose: shares the GPU's single network-interface TX port between NUM_REQ
// requesters. Plain round-robin between packets; a packet lock keeps a
// multi-flit packet contiguous until its last flit, or until the owner has
// been idle for LOCK_TIMEOUT cycles. One registered stage drives the NI.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   FLIT_W        flit width, flit = {dest_gpu[5:0], payload[9:0]} at 16
//   LOCK_TIMEOUT  owner-idle cycles before a lock is force-released, 0 = never
//
// Ports:
//   ACLK              clock, rising edge
//   ARESET            synchronous active-high reset
//   bus               gpu_net_tx_arbiter_if.slave (requester + NI handshakes)
//   grant_id          requester owning the current or last grant
//   locked            packet lock held
//   err_lock_timeout  one-cycle pulse when a lock is force-released
//   stat_flits        NI handshake count       (ARB_STATS_EN only)
//   stat_stall        NI backpressure cycles   (ARB_STATS_EN only)
//
// Build option: define ARB_STATS_EN to add the stat_flits/stat_stall counters.
module gpu_net_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FLIT_W       = 16,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  gpu_net_tx_arbiter_if.slave     bus,
  output logic [2:0]              grant_id,
  output logic                    locked,
  output logic                    err_lock_timeout
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_stall
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [3:0]  NREQ    = 4'(NUM_REQ);
  localparam bit          TO_EN   = (LOCK_TIMEOUT > 0);
  // Counter value seen on the last idle cycle before the forced release.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(LOCK_TIMEOUT - 1) : 16'd0;

  // Registered state
  state_t             state_q,   state_d;
  logic [2:0]         rr_ptr_q,  rr_ptr_d;
  logic [2:0]         lock_id_q, lock_id_d;
  logic [2:0]         grant_q,   grant_d;
  logic [15:0]        to_cnt_q,  to_cnt_d;
  logic [FLIT_W-1:0]  data_q,    data_d;
  logic               valid_q,   valid_d;
  logic               err_q,     err_d;

  // Arbitration signals
  logic [7:0]         valid_ext;
  logic [7:0]         last_ext;
  logic               win_found;
  logic [2:0]         win_id;
  logic [3:0]         idx;
  logic               can_load;
  logic               lock_valid;
  logic               acc_req;
  logic [2:0]         acc_id;
  logic               acc_last;
  logic [FLIT_W-1:0]  acc_data;
  logic               accept;

  function automatic logic [2:0] wrap_inc(input logic [2:0] k);
    logic [3:0] sum;
    sum = {1'b0, k} + 4'd1;
    if (sum >= NREQ) begin
      sum = 4'd0;
    end
    return sum[2:0];
  endfunction

  // Zero-extend the request vectors to 8 bits so a 3-bit id can index them
  // for every legal NUM_REQ.
  always_comb begin
    valid_ext              = '0;
    last_ext               = '0;
    valid_ext[NUM_REQ-1:0] = bus.req_valid;
    last_ext[NUM_REQ-1:0]  = bus.req_last;
  end

  // Round-robin search starting at rr_ptr; the first valid index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + 4'(i);
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_found && valid_ext[idx[2:0]]) begin
        win_found = 1'b1;
        win_id    = idx[2:0];
      end
    end
  end

  // Candidate selection: in LOCK only the lock owner may proceed.
  always_comb begin
    can_load   = !valid_q || bus.net_ready_in;
    lock_valid = valid_ext[lock_id_q];
    if (state_q == ST_LOCK) begin
      acc_req = lock_valid;
      acc_id  = lock_id_q;
    end else begin
      acc_req = win_found;
      acc_id  = win_id;
    end
    accept   = acc_req && can_load && !ARESET;
    acc_last = last_ext[acc_id];
    acc_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc_id == 3'(k)) begin
        acc_data = bus.req_data[k*FLIT_W +: FLIT_W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_ready[k] = accept && (acc_id == 3'(k));
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    grant_d   = grant_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = 1'b0;

    // Output stage drains on an NI handshake; a same-cycle accept refills it.
    if (valid_q && bus.net_ready_in) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      data_d   = acc_data;
      valid_d  = 1'b1;
      grant_d  = acc_id;
      to_cnt_d = 16'd0;
      if (acc_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = wrap_inc(acc_id);
      end else begin
        state_d   = ST_LOCK;
        lock_id_d = acc_id;
      end
    end else if (TO_EN && (state_q == ST_LOCK) && !lock_valid) begin
      // Only owner-idle cycles count; an owner stalled by NI backpressure
      // keeps lock_valid high and leaves the counter alone.
      if (to_cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        rr_ptr_d = wrap_inc(lock_id_q);
        to_cnt_d = 16'd0;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 3'd0;
      lock_id_q <= 3'd0;
      grant_q   <= 3'd0;
      to_cnt_q  <= 16'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      grant_q   <= grant_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.net_data_out  = data_q;
  assign bus.net_valid_out = valid_q;
  assign grant_id          = grant_q;
  assign locked            = (state_q == ST_LOCK);
  assign err_lock_timeout  = err_q;

`ifdef ARB_STATS_EN
  logic [31:0] stat_flits_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_flits_q <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (valid_q && bus.net_ready_in) begin
        stat_flits_q <= stat_flits_q + 32'd1;
      end
      if (valid_q && !bus.net_ready_in) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_gpu_net_tx_arbiter.sv
// tb/tb_gpu_net_tx_arbiter.sv - directed self-checking bench for gpu_net_tx_arbiter
module tb_gpu_net_tx_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [2:0] grant_id;
  logic       locked;
  logic       err_lock_timeout;
`ifdef ARB_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gpu_net_tx_arbiter_if #(.NUM_REQ(4), .FLIT_W(16)) bus ();

  gpu_net_tx_arbiter #(
    .NUM_REQ(4),
    .FLIT_W(16),
    .LOCK_TIMEOUT(8)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus),
    .grant_id(grant_id),
    .locked(locked),
    .err_lock_timeout(err_lock_timeout)
`ifdef ARB_STATS_EN
    ,
    .stat_flits(stat_flits),
    .stat_stall(stat_stall)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_flit(input int k, input logic [15:0] d, input logic last);
    bus.req_data[k*16 +: 16] = d;
    bus.req_last[k]          = last;
  endtask

  task automatic do_reset();
    ARESET        = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    ARESET        = 1'b0;
  endtask

  task automatic test_reset();
    ARESET           = 1'b1;
    bus.req_valid    = 4'b1111;
    bus.req_last     = 4'b1111;
    bus.req_data     = 64'h4444_3333_2222_1111;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b0 || bus.net_data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_net_out: got valid=%b data=%h want valid=0 data=0000",
               bus.net_valid_out, bus.net_data_out);
    end
    n_tests++;
    if (grant_id !== 3'd0 || locked !== 1'b0 || err_lock_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got grant=%0d locked=%b err=%b want 0/0/0",
               grant_id, locked, err_lock_timeout);
    end
    ARESET        = 1'b0;
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_single_flit();
    set_flit(0, 16'h7D23, 1'b1);
    bus.req_valid    = 4'b0001;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    n_tests++;
    if (bus.net_data_out !== 16'h7D23 || bus.net_valid_out !== 1'b1 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL single_out: got data=%h valid=%b grant=%0d want 7d23/1/0",
               bus.net_data_out, bus.net_valid_out, grant_id);
    end
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b0 || bus.net_data_out !== 16'h7D23) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b data=%h want 0/7d23",
               bus.net_valid_out, bus.net_data_out);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] rr_data [4];
    int          exp_seq [6];
    int          e;
    rr_data = '{16'h1A00, 16'h2B11, 16'h3C22, 16'h4D33};
    exp_seq = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_flit(k, rr_data[k], 1'b1);
    end
    bus.req_valid    = 4'b1111;
    bus.net_ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = exp_seq[i];
      settle();
      n_tests++;
      if (bus.req_ready !== (4'b0001 << e)) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.req_ready, 4'b0001 << e);
      end
      tick();
      n_tests++;
      if (grant_id !== 3'(e) || bus.net_data_out !== rr_data[e] || bus.net_valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got grant=%0d data=%h valid=%b want %0d/%h/1",
                 i, grant_id, bus.net_data_out, bus.net_valid_out, e, rr_data[e]);
      end
    end
    bus.req_valid = 4'b0000;
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got valid=%b want 0", bus.net_valid_out);
    end
  endtask

  task automatic test_backpressure();
    set_flit(0, 16'h0BEE, 1'b1);
    bus.req_valid    = 4'b0001;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_first_ready: got %b want 0001", bus.req_ready);
    end
    tick();
    set_flit(0, 16'h0BEF, 1'b1);
    bus.net_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_tests++;
      if (bus.req_ready !== 4'b0000 || bus.net_data_out !== 16'h0BEE || bus.net_valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ready=%b data=%h valid=%b want 0000/0bee/1",
                 i, bus.req_ready, bus.net_data_out, bus.net_valid_out);
      end
      tick();
    end
    n_tests++;
    if (bus.net_data_out !== 16'h0BEE || bus.net_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold_end: got data=%h valid=%b want 0bee/1",
               bus.net_data_out, bus.net_valid_out);
    end
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0001", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_data_out !== 16'h0BEF || bus.net_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got data=%h valid=%b want 0bef/1",
               bus.net_data_out, bus.net_valid_out);
    end
    set_flit(0, 16'h0BF0, 1'b1);
    tick();
    n_tests++;
    if (bus.net_data_out !== 16'h0BF0 || bus.net_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_third: got data=%h valid=%b want 0bf0/1",
               bus.net_data_out, bus.net_valid_out);
    end
    bus.req_valid = 4'b0000;
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%b want 0", bus.net_valid_out);
    end
  endtask

  task automatic test_packet_lock();
    logic [15:0] pkt [3];
    pkt = '{16'hA001, 16'hA002, 16'hA003};
    set_flit(2, 16'hB002, 1'b1);
    bus.net_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_flit(1, pkt[i], (i == 2));
      bus.req_valid = 4'b0110;
      settle();
      n_tests++;
      if (bus.req_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL lock_ready[%0d]: got %b want 0010", i, bus.req_ready);
      end
      tick();
      n_tests++;
      if (bus.net_data_out !== pkt[i] || grant_id !== 3'd1 || locked !== (i != 2)) begin
        n_fail++;
        $display("FAIL lock_out[%0d]: got data=%h grant=%0d locked=%b want %h/1/%b",
                 i, bus.net_data_out, grant_id, locked, pkt[i], (i != 2));
      end
    end
    bus.req_valid = 4'b0100;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_next_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_data_out !== 16'hB002 || grant_id !== 3'd2 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_next_out: got data=%h grant=%0d locked=%b want b002/2/0",
               bus.net_data_out, grant_id, locked);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_lock_timeout();
    set_flit(1, 16'hC001, 1'b0);
    set_flit(2, 16'hE002, 1'b1);
    bus.req_valid    = 4'b0110;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_first_ready: got %b want 0010", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_data_out !== 16'hC001 || locked !== 1'b1 || grant_id !== 3'd1) begin
      n_fail++;
      $display("FAIL to_first_out: got data=%h locked=%b grant=%0d want c001/1/1",
               bus.net_data_out, locked, grant_id);
    end
    bus.req_valid = 4'b0100;
    for (int n = 1; n <= 7; n++) begin
      settle();
      n_tests++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL to_locked_ready[%0d]: got %b want 0000", n, bus.req_ready);
      end
      tick();
      n_tests++;
      if (err_lock_timeout !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: got err=%b locked=%b want 0/1", n, err_lock_timeout, locked);
      end
    end
    tick();
    n_tests++;
    if (err_lock_timeout !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fire: got err=%b locked=%b want 1/0", err_lock_timeout, locked);
    end
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_resume_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    n_tests++;
    if (err_lock_timeout !== 1'b0 || grant_id !== 3'd2 || bus.net_data_out !== 16'hE002 ||
        bus.net_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL to_resume_out: got err=%b grant=%0d data=%h valid=%b want 0/2/e002/1",
               err_lock_timeout, grant_id, bus.net_data_out, bus.net_valid_out);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    set_flit(2, 16'hD002, 1'b0);
    bus.req_valid    = 4'b0100;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmp_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    set_flit(2, 16'hD003, 1'b0);
    bus.net_ready_in = 1'b0;
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b1 || bus.net_data_out !== 16'hD002 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rmp_pre: got valid=%b data=%h locked=%b want 1/d002/1",
               bus.net_valid_out, bus.net_data_out, locked);
    end
    ARESET           = 1'b1;
    bus.net_ready_in = 1'b1;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmp_ready_in_reset: got %b want 0000", bus.req_ready);
    end
    tick();
    n_tests++;
    if (bus.net_valid_out !== 1'b0 || locked !== 1'b0 || grant_id !== 3'd0 ||
        bus.net_data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmp_post: got valid=%b locked=%b grant=%0d data=%h want 0/0/0/0000",
               bus.net_valid_out, locked, grant_id, bus.net_data_out);
    end
    ARESET = 1'b0;
    set_flit(1, 16'h8111, 1'b1);
    set_flit(2, 16'h8222, 1'b1);
    set_flit(3, 16'h8333, 1'b1);
    bus.req_valid = 4'b1110;
    settle();
    n_tests++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmp_first_ready: got %b want 0010", bus.req_ready);
    end
    tick();
    n_tests++;
    if (grant_id !== 3'd1 || bus.net_data_out !== 16'h8111) begin
      n_fail++;
      $display("FAIL rmp_first_grant: got grant=%0d data=%h want 1/8111",
               grant_id, bus.net_data_out);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    ARESET           = 1'b1;
    bus.req_valid    = 4'b0000;
    bus.req_last     = 4'b0000;
    bus.req_data     = 64'd0;
    bus.net_ready_in = 1'b0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_lock_timeout();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
